// File: rtl/loop_controller.sv
// Hardware loop stack: 4-deep LIFO of {count, pc}, branch/last-iteration pulses, sticky fault.
// Optional LOOP_ZERO_SKIP_EN: a zero count skips the body instead of running it once.
module loop_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        loop_start,
  input  logic [15:0] loop_count,
  input  logic [15:0] loop_pc,
  input  logic        loop_end,
  input  logic        fault_clr,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic        last_iter,
`ifdef LOOP_ZERO_SKIP_EN
  output logic        skip_body,
`endif
  output logic [2:0]  depth,
  output logic [15:0] cur_count,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [15:0] pc_q  [4];
  logic [15:0] pc_d  [4];
  logic [2:0]  depth_q, depth_d;
  logic        bt_q, bt_d;
  logic        li_q, li_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] cc_q, cc_d;
  logic [15:0] tgt_q, tgt_d;
  logic [1:0]  cur_idx, nxt_idx;
  logic [15:0] push_cnt;
`ifdef LOOP_ZERO_SKIP_EN
  logic        sk_q, sk_d;
`endif

  assign cur_idx  = 2'(depth_q - 3'd1);
  assign push_cnt = (loop_count == 16'd0) ? 16'd1 : loop_count;

  always_comb begin : next_state
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    bt_d    = 1'b0;
    li_d    = 1'b0;
    fault_d = fault_q;
    code_d  = code_q;
`ifdef LOOP_ZERO_SKIP_EN
    sk_d    = 1'b0;
`endif
    if (fault_clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
        pc_d[i]  = '0;
      end
      depth_d = '0;
      state_d = IDLE;
      fault_d = 1'b0;
      code_d  = 2'b00;
    end else if (state_q != FAULT) begin
      if (loop_start && loop_end) begin
        fault_d = 1'b1;
        code_d  = 2'b11;
        state_d = FAULT;
      end else if (loop_start) begin
        if (depth_q == 3'd4) begin
          fault_d = 1'b1;
          code_d  = 2'b01;
          state_d = FAULT;
`ifdef LOOP_ZERO_SKIP_EN
        end else if (loop_count == 16'd0) begin
          sk_d = 1'b1;
`endif
        end else begin
          cnt_d[depth_q[1:0]] = push_cnt;
          pc_d[depth_q[1:0]]  = loop_pc;
          depth_d = depth_q + 3'd1;
          state_d = RUN;
        end
      end else if (loop_end) begin
        if (depth_q == 3'd0) begin
          fault_d = 1'b1;
          code_d  = 2'b10;
          state_d = FAULT;
        end else if (cnt_q[cur_idx] > 16'd1) begin
          cnt_d[cur_idx] = cnt_q[cur_idx] - 16'd1;
          bt_d = 1'b1;
        end else begin
          cnt_d[cur_idx] = '0;
          pc_d[cur_idx]  = '0;
          depth_d = depth_q - 3'd1;
          li_d    = 1'b1;
          state_d = (depth_d == 3'd0) ? IDLE : RUN;
        end
      end
    end
  end

  // Top-of-stack view is registered from the post-update stack.
  always_comb begin : top_sel
    nxt_idx = 2'(depth_d - 3'd1);
    cc_d    = '0;
    tgt_d   = '0;
    if (depth_d != 3'd0) begin
      cc_d  = cnt_d[nxt_idx];
      tgt_d = pc_d[nxt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      bt_q    <= 1'b0;
      li_q    <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      cc_q    <= '0;
      tgt_q   <= '0;
`ifdef LOOP_ZERO_SKIP_EN
      sk_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bt_q    <= bt_d;
      li_q    <= li_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cc_q    <= cc_d;
      tgt_q   <= tgt_d;
`ifdef LOOP_ZERO_SKIP_EN
      sk_q    <= sk_d;
`endif
    end
  end

  assign branch_taken  = bt_q;
  assign branch_target = tgt_q;
  assign last_iter     = li_q;
  assign depth         = depth_q;
  assign cur_count     = cc_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;
`ifdef LOOP_ZERO_SKIP_EN
  assign skip_body     = sk_q;
`endif

endmodule

// File: tb/tb_loop_controller.sv
// Scoreboard bench for loop_controller: expected outputs queued per stimulus cycle,
// popped and compared one edge later.
module tb_loop_controller;

  logic        clk = 1'b0;
  logic        reset, loop_start, loop_end, fault_clr;
  logic [15:0] loop_count, loop_pc;
  logic        branch_taken, last_iter, fault;
  logic [15:0] branch_target, cur_count;
  logic [2:0]  depth;
  logic [1:0]  fault_code;
`ifdef LOOP_ZERO_SKIP_EN
  logic        skip_body;
`endif

  always #5 clk = ~clk;

  loop_controller dut (
    .clk           (clk),
    .reset         (reset),
    .loop_start    (loop_start),
    .loop_count    (loop_count),
    .loop_pc       (loop_pc),
    .loop_end      (loop_end),
    .fault_clr     (fault_clr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .last_iter     (last_iter),
`ifdef LOOP_ZERO_SKIP_EN
    .skip_body     (skip_body),
`endif
    .depth         (depth),
    .cur_count     (cur_count),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  typedef struct {
    string       tag;
    logic        bt;
    logic [15:0] tgt;
    logic        li;
    logic        sk;
    logic [2:0]  dep;
    logic [15:0] cc;
    logic        f;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t mk(string tag, logic bt, logic [15:0] tgt,
                              logic li, logic sk, logic [2:0] dep,
                              logic [15:0] cc, logic f, logic [1:0] code);
    exp_t x;
    x.tag = tag; x.bt = bt; x.tgt = tgt; x.li = li; x.sk = sk;
    x.dep = dep; x.cc = cc; x.f = f; x.code = code;
    return x;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic e,
                     input logic c, input logic [15:0] cnt,
                     input logic [15:0] pc, input exp_t x);
    exp_t y;
    reset = r; loop_start = s; loop_end = e; fault_clr = c;
    loop_count = cnt; loop_pc = pc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({y.tag, ".bt"},    32'(branch_taken), 32'(y.bt));
    chk({y.tag, ".li"},    32'(last_iter),    32'(y.li));
    chk({y.tag, ".depth"}, 32'(depth),        32'(y.dep));
    chk({y.tag, ".cnt"},   32'(cur_count),    32'(y.cc));
    chk({y.tag, ".fault"}, 32'(fault),        32'(y.f));
    chk({y.tag, ".code"},  32'(fault_code),   32'(y.code));
    if (y.bt || y.dep != 3'd0 || r)
      chk({y.tag, ".tgt"}, 32'(branch_target), 32'(y.tgt));
`ifdef LOOP_ZERO_SKIP_EN
    chk({y.tag, ".skip"},  32'(skip_body),    32'(y.sk));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; loop_start = 1'b0; loop_end = 1'b0; fault_clr = 1'b0;
    loop_count = '0; loop_pc = '0;
    @(negedge clk);
    cyc(1,0,0,0,0,0, mk("rst",0,0,0,0,0,0,0,0));

    // single loop, three iterations
    cyc(0,1,0,0,3,16'h0040, mk("s3",0,16'h40,0,0,1,3,0,0));
    cyc(0,0,1,0,0,0, mk("e1",1,16'h40,0,0,1,2,0,0));
    cyc(0,0,1,0,0,0, mk("e2",1,16'h40,0,0,1,1,0,0));
    cyc(0,0,1,0,0,0, mk("e3",0,0,1,0,0,0,0,0));
    cyc(0,0,0,0,0,0, mk("idle",0,0,0,0,0,0,0,0));

    // nested loops
    cyc(0,1,0,0,2,16'h0010, mk("outer",0,16'h10,0,0,1,2,0,0));
    cyc(0,1,0,0,2,16'h0020, mk("inner",0,16'h20,0,0,2,2,0,0));
    cyc(0,0,1,0,0,0, mk("n1",1,16'h20,0,0,2,1,0,0));
    cyc(0,0,1,0,0,0, mk("n2",0,16'h10,1,0,1,2,0,0));
    cyc(0,0,1,0,0,0, mk("n3",1,16'h10,0,0,1,1,0,0));
    cyc(0,0,1,0,0,0, mk("n4",0,0,1,0,0,0,0,0));

    // overflow
    for (int i = 0; i < 4; i++)
      cyc(0,1,0,0,1,16'(16'h100 + i),
          mk("push",0,16'(16'h100 + i),0,0,3'(i + 1),1,0,0));
    cyc(0,1,0,0,1,16'h0200, mk("ovf",0,16'h103,0,0,4,1,1,2'b01));
    cyc(0,0,1,0,0,0, mk("fend",0,16'h103,0,0,4,1,1,2'b01));
    cyc(0,1,0,0,7,16'h0300, mk("fstart",0,16'h103,0,0,4,1,1,2'b01));
    cyc(0,0,0,1,0,0, mk("clr1",0,0,0,0,0,0,0,0));

    // underflow and collision
    cyc(0,0,1,0,0,0, mk("unf",0,0,0,0,0,0,1,2'b10));
    cyc(0,0,0,1,0,0, mk("clr2",0,0,0,0,0,0,0,0));
    cyc(0,1,0,0,5,16'h0200, mk("s5",0,16'h200,0,0,1,5,0,0));
    cyc(0,1,1,0,9,16'h0300, mk("coll",0,16'h200,0,0,1,5,1,2'b11));
    cyc(0,1,1,1,9,16'h0300, mk("clrpri",0,0,0,0,0,0,0,0));

    // zero count
`ifdef LOOP_ZERO_SKIP_EN
    cyc(0,1,0,0,0,16'h0300, mk("zskip",0,0,0,1,0,0,0,0));
    cyc(0,0,0,0,0,0, mk("zidle",0,0,0,0,0,0,0,0));
`else
    cyc(0,1,0,0,0,16'h0300, mk("zpush",0,16'h300,0,0,1,1,0,0));
    cyc(0,0,1,0,0,0, mk("zend",0,0,1,0,0,0,0,0));
    cyc(0,0,0,0,0,0, mk("zidle",0,0,0,0,0,0,0,0));
`endif

    // reset during RUN with depth 2
    cyc(0,1,0,0,2,16'h0010, mk("r1",0,16'h10,0,0,1,2,0,0));
    cyc(0,1,0,0,3,16'h0020, mk("r2",0,16'h20,0,0,2,3,0,0));
    cyc(1,0,1,1,0,0, mk("rrun",0,0,0,0,0,0,0,0));
    cyc(0,0,1,0,0,0, mk("postr",0,0,0,0,0,0,1,2'b10));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
